chunked_carry_adder: RTL

- Multi-cycle, parametrised successor to the single-cycle ripple-carry adder.
- Adds or subtracts two NUMBITS operands, CHUNKBITS bits per clock, rippling the carry between cycles through a register.
- Uses a valid/ready handshake on both input and output.
- Sits in the datapath where a full-width combinational carry chain would miss timing.

---
 rtl/chunked_carry_adder_pkg.sv | 13 +
 rtl/chunked_carry_adder_chunk.sv | 21 ++
 rtl/chunked_carry_adder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/chunked_carry_adder_pkg.sv
// Shared encodings for the chunked carry adder: FSM states and operation modes.
package chunked_carry_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/chunked_carry_adder_chunk.sv
// Combinational W-bit ripple adder for one chunk; also reports the carry into its top bit.
module chunk_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         msb_cin
);

   logic [W:0] total;

   assign total   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign sum     = total[W-1:0];
   assign cout    = total[W];
   // Top sum bit is a^b^carry_in at that position, so the carry can be recovered from it.
   assign msb_cin = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/chunked_carry_adder.sv
// Multi-cycle adder/subtractor: CHUNKBITS per clock, carry rippled through a register.
// Optional signed-overflow output enabled by CHUNKED_ADDER_OVERFLOW_EN.
module chunked_carry_adder
   import chunked_carry_adder_pkg::*;
#(
   parameter int NUMBITS   = 32,
   parameter int CHUNKBITS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUMBITS-1:0] A,
   input  logic [NUMBITS-1:0] B,
   input  logic               carryin,
   input  logic               mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUMBITS-1:0] result,
   output logic               carryout
`ifdef CHUNKED_ADDER_OVERFLOW_EN
   ,
   output logic               overflow
`endif
);

   localparam int NCHUNKS = NUMBITS / CHUNKBITS;
   localparam int IDXW    = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNKS - 1);

   state_e              state_q, state_d;
   logic [IDXW-1:0]     idx_q, idx_d;
   logic                carry_q, carry_d;
   logic [NUMBITS-1:0]  a_q, a_d;
   logic [NUMBITS-1:0]  b_q, b_d;
   logic [NUMBITS-1:0]  result_q, result_d;
   logic                carryout_q, carryout_d;

   logic [CHUNKBITS-1:0] a_slice, b_slice, chunk_sum;
   logic                 chunk_cout, chunk_msb_cin;
   logic                 accept;

   // One adder shared by every chunk; the index selects which slice it sees.
   assign a_slice = a_q[int'(idx_q) * CHUNKBITS +: CHUNKBITS];
   assign b_slice = b_q[int'(idx_q) * CHUNKBITS +: CHUNKBITS];

   chunk_adder #(.W(CHUNKBITS)) u_chunk (
      .a       (a_slice),
      .b       (b_slice),
      .cin     (carry_q),
      .sum     (chunk_sum),
      .cout    (chunk_cout),
      .msb_cin (chunk_msb_cin)
   );

   assign out_valid = (state_q == DONE);
   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign result    = result_q;
   assign carryout  = carryout_q;

`ifdef CHUNKED_ADDER_OVERFLOW_EN
   logic overflow_q, overflow_d;
   assign overflow = overflow_q;
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      carryout_d = carryout_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
      overflow_d = overflow_q;
`endif
      case (state_q)
         RUN: begin
            result_d[int'(idx_q) * CHUNKBITS +: CHUNKBITS] = chunk_sum;
            carry_d = chunk_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               carryout_d = chunk_cout;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
               overflow_d = chunk_msb_cin ^ chunk_cout;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready && !in_valid) state_d = IDLE;
         end
         default: ;
      endcase
      // Accept overrides DONE retirement so a back-to-back op starts without a bubble.
      if (accept) begin
         a_d        = A;
         b_d        = (mode == MODE_SUB) ? ~B : B;
         carry_d    = (mode == MODE_SUB) ? 1'b1 : carryin;
         result_d   = '0;
         carryout_d = 1'b0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
         overflow_d = 1'b0;
`endif
         idx_d      = '0;
         state_d    = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         carryout_q <= 1'b0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
         overflow_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         a_q        <= a_d;
         b_q        <= b_d;
         result_q   <= result_d;
         carryout_q <= carryout_d;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
         overflow_q <= overflow_d;
`endif
      end
   end

`ifndef CHUNKED_ADDER_OVERFLOW_EN
   // Carry into the MSB only feeds the optional overflow flag.
   logic unused_msb_cin;
   assign unused_msb_cin = chunk_msb_cin;
`endif

endmodule
